// File: rtl/alu_exec_pkg.sv
// Shared constants for the ALU execute stage: control codes, default width and buffer depth.
// Optional feature macro: ALU_EXEC_OVF_EN (adds signed-overflow flag).
package alu_exec_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_NOR = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  localparam int ALU_WIDTH = 32;
  localparam int DEPTH     = 2;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (alu_ctr, a, b) -> res, plus signed overflow when ALU_EXEC_OVF_EN is defined.
module alu_core
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
`ifdef ALU_EXEC_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic slt_bit;

  assign slt_bit = ($signed(a) < $signed(b));

  always_comb begin
    res = '0;
    case (alu_ctr)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, slt_bit};
      ALU_XOR: res = a ^ b;
      ALU_NOR: res = ~(a | b);
      ALU_SLL: res = a << b[4:0];
    endcase
  end

`ifdef ALU_EXEC_OVF_EN
  // Overflow only exists for the arithmetic codes; judged from operand and result sign bits.
  always_comb begin
    ovf = 1'b0;
    case (alu_ctr)
      ALU_ADD: ovf = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      ALU_SUB: ovf = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes on accept and parks results in a 2-entry FIFO with valid/ready on both sides.
// Optional feature macro: ALU_EXEC_OVF_EN (adds the ovf output and per-entry overflow storage).
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_EXEC_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] core_res;
  logic [WIDTH-1:0] res_mem [DEPTH];
  logic             zero_mem [DEPTH];
  logic [WIDTH-1:0] last_res;
  logic             last_zero;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

`ifdef ALU_EXEC_OVF_EN
  logic             core_ovf;
  logic             ovf_mem [DEPTH];
  logic             last_ovf;
`endif

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .alu_ctr (alu_ctr),
    .a       (op_a),
    .b       (op_b),
    .res     (core_res)
`ifdef ALU_EXEC_OVF_EN
    ,
    .ovf     (core_ovf)
`endif
  );

  // Ready depends only on registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (count != 2'(DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // When empty the outputs show the most recently popped entry rather than stale storage.
  assign result = out_valid ? res_mem[rd_ptr]  : last_res;
  assign zero   = out_valid ? zero_mem[rd_ptr] : last_zero;
`ifdef ALU_EXEC_OVF_EN
  assign ovf    = out_valid ? ovf_mem[rd_ptr]  : last_ovf;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      last_res  <= '0;
      last_zero <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        res_mem[i]  <= '0;
        zero_mem[i] <= 1'b0;
      end
`ifdef ALU_EXEC_OVF_EN
      last_ovf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ovf_mem[i] <= 1'b0;
      end
`endif
    end else begin
      if (push) begin
        res_mem[wr_ptr]  <= core_res;
        zero_mem[wr_ptr] <= (core_res == '0);
`ifdef ALU_EXEC_OVF_EN
        ovf_mem[wr_ptr]  <= core_ovf;
`endif
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        last_res  <= res_mem[rd_ptr];
        last_zero <= zero_mem[rd_ptr];
`ifdef ALU_EXEC_OVF_EN
        last_ovf  <= ovf_mem[rd_ptr];
`endif
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed spec scenarios then random traffic against a queue model.
// Honours ALU_EXEC_OVF_EN when defined for both the DUT port and the reference model.
module tb_alu_exec_stage;
  import alu_exec_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
  } entry_t;

  localparam longint MAX_S = 64'sh7FFF_FFFF;
  localparam longint MIN_S = -64'sh8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_ctr = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
`ifdef ALU_EXEC_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;
  entry_t model_q[$];
  entry_t last_pop;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctr   (alu_ctr),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
`ifdef ALU_EXEC_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU built from signed/unsigned arithmetic on wide integers.
  function automatic entry_t ref_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    entry_t e;
    longint sa;
    longint sb;
    longint s;
    logic [63:0] wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.ov = 1'b0;
    e.res = '0;
    case (c)
      3'd0: begin s = sa + sb; e.res = s[31:0]; e.ov = (s > MAX_S) || (s < MIN_S); end
      3'd1: begin s = sa - sb; e.res = s[31:0]; e.ov = (s > MAX_S) || (s < MIN_S); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = (sa < sb) ? 32'd1 : 32'd0;
      3'd5: e.res = a ^ b;
      3'd6: e.res = ~(a | b);
      3'd7: begin wide = 64'(a) * (64'd1 << b[4:0]); e.res = wide[31:0]; end
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    entry_t exp;
    exp = (model_q.size() != 0) ? model_q[0] : last_pop;
    check_value("in_ready", 32'(in_ready), 32'(model_q.size() != 2));
    check_value("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    check_value("result", result, exp.res);
    check_value("zero", 32'(zero), 32'(exp.z));
`ifdef ALU_EXEC_OVF_EN
    check_value("ovf", 32'(ovf), 32'(exp.ov));
`endif
  endtask

  // One clock: check current outputs, drive inputs, advance the model, step past the edge.
  task automatic apply_stimulus(input logic v, input logic [2:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic ordy);
    bit do_push;
    bit do_pop;
    check_output();
    in_valid  = v;
    alu_ctr   = c;
    op_a      = a;
    op_b      = b;
    out_ready = ordy;
    do_push = v && (model_q.size() != 2);
    do_pop  = ordy && (model_q.size() != 0);
    if (do_pop) last_pop = model_q.pop_front();
    if (do_push) model_q.push_back(ref_op(c, a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    alu_ctr  = ALU_ADD;
    op_a     = 32'd100;
    op_b     = 32'd200;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    model_q.delete();
    last_pop = '{res: 32'd0, z: 1'b0, ov: 1'b0};
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    last_pop = '{res: 32'd0, z: 1'b0, ov: 1'b0};
    @(posedge clk);
    #1;
    do_reset();
    check_value("reset_out_valid", 32'(out_valid), 32'd0);
    check_value("reset_result", result, 32'd0);
    check_value("reset_in_ready", 32'(in_ready), 32'd1);

    // Basic single-cycle latency and per-code results.
    apply_stimulus(1'b1, ALU_ADD, 32'd5, 32'd7, 1'b1);
    check_value("add_5_7", result, 32'd12);
    check_value("add_5_7_zero", 32'(zero), 32'd0);
    check_value("add_5_7_valid", 32'(out_valid), 32'd1);
    apply_stimulus(1'b1, ALU_SUB, 32'd9, 32'd9, 1'b1);
    check_value("sub_9_9", result, 32'd0);
    check_value("sub_9_9_zero", 32'(zero), 32'd1);
    apply_stimulus(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1);
    check_value("slt_neg", result, 32'd1);
    apply_stimulus(1'b1, ALU_SLL, 32'd1, 32'd31, 1'b1);
    check_value("sll_31", result, 32'h8000_0000);
    apply_stimulus(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);

    // Fill with a stalled consumer, then release.
    apply_stimulus(1'b1, ALU_ADD, 32'd1, 32'd1, 1'b0);
    apply_stimulus(1'b1, ALU_ADD, 32'd2, 32'd2, 1'b0);
    check_value("full_in_ready", 32'(in_ready), 32'd0);
    apply_stimulus(1'b1, ALU_ADD, 32'd3, 32'd3, 1'b0);
    check_value("full_head", result, 32'd2);
    apply_stimulus(1'b1, ALU_ADD, 32'd3, 32'd3, 1'b1);
    check_value("pop_while_full_head", result, 32'd4);
    check_value("pop_while_full_ready", 32'(in_ready), 32'd1);
    apply_stimulus(1'b1, ALU_ADD, 32'd3, 32'd3, 1'b1);
    check_value("third_op", result, 32'd6);
    apply_stimulus(1'b0, ALU_AND, 32'd0, 32'd0, 1'b1);
    check_value("empty_hold_result", result, 32'd6);
    check_value("empty_valid", 32'(out_valid), 32'd0);
    apply_stimulus(1'b0, ALU_AND, 32'd0, 32'd0, 1'b1);

    // Reset while full discards everything.
    apply_stimulus(1'b1, ALU_ADD, 32'd10, 32'd20, 1'b0);
    apply_stimulus(1'b1, ALU_ADD, 32'd30, 32'd40, 1'b0);
    do_reset();
    check_value("rst_full_valid", 32'(out_valid), 32'd0);
    check_value("rst_full_result", result, 32'd0);
    check_value("rst_full_ready", 32'(in_ready), 32'd1);
    apply_stimulus(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
    apply_stimulus(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);

`ifdef ALU_EXEC_OVF_EN
    apply_stimulus(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
    check_value("ovf_add", 32'(ovf), 32'd1);
    apply_stimulus(1'b1, ALU_SUB, 32'h8000_0000, 32'd1, 1'b1);
    check_value("ovf_sub", 32'(ovf), 32'd1);
    apply_stimulus(1'b1, ALU_AND, 32'h8000_0000, 32'h8000_0000, 1'b1);
    check_value("ovf_and", 32'(ovf), 32'd0);
    apply_stimulus(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
`endif

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                     pick_operand(), pick_operand(), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
    end
    check_output();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
